tx_arp: RTL and testbench

TX_ARP -- requirements
Module: tx_arp

---
 rtl/tx_arp_pkg.sv | 43 ++++
 rtl/tx_arp.sv | 128 ++++++++++++
 tb/tb_tx_arp.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tx_arp_pkg.sv
// Shared ARP frame constants, state encoding and the frame builder for tx_arp.
package tx_arp_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned FRAME_WORDS = 21;
  localparam int unsigned FRAME_W     = WORD_W * FRAME_WORDS;
  localparam int unsigned IDX_W       = 5;

  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] HLEN_PLEN    = 16'h0604;
  localparam logic [15:0] OP_REQUEST   = 16'h0001;
  localparam logic [15:0] OP_REPLY     = 16'h0002;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_ZERO  = 48'h0000_0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Per-frame snapshot of everything the frame content depends on.
  typedef struct packed {
    logic        reply;
    logic [47:0] mac_d;
    logic [47:0] mac_s;
    logic [31:0] sip;
    logic [31:0] dip;
  } arp_cfg_t;

  function automatic logic [FRAME_W-1:0] build_frame(input arp_cfg_t c);
    return {c.reply ? c.mac_d : MAC_BCAST,
            c.mac_s,
            ETH_TYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN_PLEN,
            c.reply ? OP_REPLY : OP_REQUEST,
            c.mac_s, c.sip,
            c.reply ? c.mac_d : MAC_ZERO,
            c.dip};
  endfunction

endpackage

// File: rtl/tx_arp.sv
// ARP request/reply frame generator: periodic broadcast requests plus on-demand
// replies, streamed as 16-bit big-endian words under ready/valid flow control.
module tx_arp
  import tx_arp_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SECOND_CNT = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack_en,
  input  logic [31:0]       cfg_sip,
  input  logic [31:0]       cfg_dip,
  input  logic [47:0]       cfg_mac_s,
  input  logic [47:0]       ack_mac_d,
  output logic [DATA_W-1:0] tx_arp_data,
  output logic              tx_arp_vld,
  output logic              tx_arp_sop,
  output logic              tx_arp_eop,
  input  logic              tx_arp_rdy,
  output logic              tx_arp_mty
);

  localparam int unsigned TIMER_W = (SECOND_CNT > 1) ? $clog2(SECOND_CNT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SECOND_CNT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(FRAME_WORDS - 1);

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic                req_pend, req_n;
  logic                rep_pend, rep_n;
  logic [IDX_W-1:0]    idx, idx_n;
  arp_cfg_t            cfg_q, cfg_n;
  logic [DATA_W-1:0]   data_n;
  logic                vld_n, sop_n, eop_n, mty_n;

  logic                wrap_c, last_c, start_c;
  logic [FRAME_W-1:0]  frame_c;
  logic [WORD_W-1:0]   word_c;

  // Word-index mux over the frame assembled from the captured snapshot.
  always_comb begin
    frame_c = build_frame(cfg_q);
    word_c  = '0;
    for (int unsigned i = 0; i < FRAME_WORDS; i++) begin
      if (idx == IDX_W'(i)) word_c = frame_c[FRAME_W-1-WORD_W*i -: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      req_pend    <= 1'b0;
      rep_pend    <= 1'b0;
      idx         <= '0;
      cfg_q       <= '0;
      tx_arp_data <= '0;
      tx_arp_vld  <= 1'b0;
      tx_arp_sop  <= 1'b0;
      tx_arp_eop  <= 1'b0;
      tx_arp_mty  <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      req_pend    <= req_n;
      rep_pend    <= rep_n;
      idx         <= idx_n;
      cfg_q       <= cfg_n;
      tx_arp_data <= data_n;
      tx_arp_vld  <= vld_n;
      tx_arp_sop  <= sop_n;
      tx_arp_eop  <= eop_n;
      tx_arp_mty  <= mty_n;
    end
  end

  always_comb begin
    wrap_c  = (timer == TIMER_LAST);
    last_c  = (idx == LAST_IDX);
    start_c = 1'b0;
    timer_n = wrap_c ? '0 : timer + TIMER_W'(1);
    req_n   = req_pend | wrap_c;
    rep_n   = rep_pend | ack_en;
    state_n = state;
    idx_n   = idx;
    cfg_n   = cfg_q;
    data_n  = tx_arp_data;
    vld_n   = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    mty_n   = 1'b0;

    unique case (state)
      ST_IDLE: start_c = rep_pend | req_pend;
      ST_SEND: begin
        if (tx_arp_rdy) begin
          vld_n  = 1'b1;
          data_n = DATA_W'(word_c);
          sop_n  = (idx == '0);
          eop_n  = last_c;
          if (last_c) begin
            state_n = ST_IDLE;
            // Chain straight into the next frame so its sop can follow this eop.
            start_c = rep_pend | req_pend;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Frame start: snapshot inputs and retire the served flag (reply first).
    if (start_c) begin
      state_n     = ST_SEND;
      idx_n       = '0;
      cfg_n.reply = rep_pend;
      cfg_n.mac_d = ack_mac_d;
      cfg_n.mac_s = cfg_mac_s;
      cfg_n.sip   = cfg_sip;
      cfg_n.dip   = cfg_dip;
      if (rep_pend) rep_n = ack_en;
      else          req_n = wrap_c;
    end
  end

endmodule

// File: tb/tb_tx_arp.sv
// Directed self-checking bench for tx_arp with a 50-cycle request period.
module tb_tx_arp;

  localparam int unsigned SC = 50;

  localparam logic [335:0] REPLY_F = {
    16'h0102, 16'h0304, 16'h0506, 16'h2C02, 16'h0304, 16'h0507, 16'h0806,
    16'h0001, 16'h0800, 16'h0604, 16'h0002, 16'h2C02, 16'h0304, 16'h0507,
    16'hC0A8, 16'h010A, 16'h0102, 16'h0304, 16'h0506, 16'hC0A8, 16'h0109};
  localparam logic [335:0] REQ_F = {
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2C02, 16'h0304, 16'h0507, 16'h0806,
    16'h0001, 16'h0800, 16'h0604, 16'h0001, 16'h2C02, 16'h0304, 16'h0507,
    16'hC0A8, 16'h010A, 16'h0000, 16'h0000, 16'h0000, 16'hC0A8, 16'h0109};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack_en = 1'b0;
  logic [31:0] cfg_sip = 32'hC0A8_010A;
  logic [31:0] cfg_dip = 32'hC0A8_0109;
  logic [47:0] cfg_mac_s = 48'h2C02_0304_0507;
  logic [47:0] ack_mac_d = 48'h0102_0304_0506;
  logic [15:0] tx_arp_data;
  logic        tx_arp_vld, tx_arp_sop, tx_arp_eop, tx_arp_mty;
  logic        tx_arp_rdy = 1'b1;

  int cycle;
  int checks = 0;
  int errors = 0;
  int sc;
  bit found;

  tx_arp #(.DATA_W(16), .SECOND_CNT(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ack_en      (ack_en),
    .cfg_sip     (cfg_sip),
    .cfg_dip     (cfg_dip),
    .cfg_mac_s   (cfg_mac_s),
    .ack_mac_d   (ack_mac_d),
    .tx_arp_data (tx_arp_data),
    .tx_arp_vld  (tx_arp_vld),
    .tx_arp_sop  (tx_arp_sop),
    .tx_arp_eop  (tx_arp_eop),
    .tx_arp_rdy  (tx_arp_rdy),
    .tx_arp_mty  (tx_arp_mty)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; sampled at negedge it equals the edge number.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle <= 0;
    else        cycle <= cycle + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Collect one frame of 21 valid words; optionally stall rdy or disturb inputs.
  task automatic get_frame(input string tag, input logic [335:0] exp, input int stall_at,
                           input bit poke, output int sop_cycle);
    logic [15:0] w;
    bit got_vld;
    sop_cycle = -1;
    for (int i = 0; i < 21; i++) begin
      got_vld = 1'b0;
      for (int n = 0; n < 200 && !got_vld; n++) begin
        @(negedge clk);
        got_vld = tx_arp_vld;
      end
      if (!got_vld) begin
        check($sformatf("%s_timeout_w%0d", tag, i), 64'd0, 64'd1);
        return;
      end
      w = exp[335-16*i -: 16];
      if (i == 0) sop_cycle = cycle;
      check($sformatf("%s_data_w%0d", tag, i), 64'(tx_arp_data), 64'(w));
      check($sformatf("%s_sopeop_w%0d", tag, i), 64'({tx_arp_sop, tx_arp_eop}),
            64'({i == 0, i == 20}));
      check($sformatf("%s_mty_w%0d", tag, i), 64'(tx_arp_mty), 64'd0);
      if (poke && i == 2) begin
        cfg_sip   = 32'h0A0A_0A0A;
        cfg_dip   = 32'h0B0B_0B0B;
        cfg_mac_s = 48'hAABB_CCDD_EEFF;
        ack_mac_d = 48'h1122_3344_5566;
      end
      if (i == stall_at) begin
        tx_arp_rdy = 1'b0;
        @(negedge clk);
        check($sformatf("%s_stall1", tag), 64'(tx_arp_vld), 64'd0);
        @(negedge clk);
        check($sformatf("%s_stall2", tag), 64'(tx_arp_vld), 64'd0);
        tx_arp_rdy = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_vld",  64'(tx_arp_vld),  64'd0);
    check("rst_sop",  64'(tx_arp_sop),  64'd0);
    check("rst_eop",  64'(tx_arp_eop),  64'd0);
    check("rst_mty",  64'(tx_arp_mty),  64'd0);
    check("rst_data", 64'(tx_arp_data), 64'd0);
    rst_n = 1'b1;

    // Reply on ack_en sampled at edge 10.
    while (cycle < 9) @(negedge clk);
    ack_en = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    get_frame("reply", REPLY_F, -1, 1'b0, sc);
    check("reply_start", 64'(sc), 64'd12);

    // Periodic broadcast requests.
    get_frame("req1", REQ_F, -1, 1'b0, sc);
    check("req1_start", 64'(sc), 64'd52);
    get_frame("req2", REQ_F, 7, 1'b0, sc);
    check("req2_start", 64'(sc), 64'd102);

    // ack_en coincident with the timer wrap at edge 150.
    while (cycle < 149) @(negedge clk);
    ack_en = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    get_frame("both_rep", REPLY_F, -1, 1'b0, sc);
    check("both_rep_start", 64'(sc), 64'd152);
    get_frame("both_req", REQ_F, -1, 1'b0, sc);
    check("both_req_start", 64'(sc), 64'd173);

    // Abort the request frame starting at edge 202 with an async reset.
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = tx_arp_vld;
    end
    check("abort_found", 64'(found), 64'd1);
    check("abort_sop", 64'(tx_arp_sop), 64'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_vld",  64'(tx_arp_vld),  64'd0);
    check("abort_sop0", 64'(tx_arp_sop),  64'd0);
    check("abort_eop",  64'(tx_arp_eop),  64'd0);
    check("abort_mty",  64'(tx_arp_mty),  64'd0);
    check("abort_data", 64'(tx_arp_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(tx_arp_vld), 64'd0);

    // Clean restart; inputs changed mid-frame must not leak into the frame.
    while (cycle < 9) @(negedge clk);
    ack_en = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    get_frame("post_rst", REPLY_F, -1, 1'b1, sc);
    check("post_rst_start", 64'(sc), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
